// File: rtl/bit_serializer.sv
// Serial front end for a WIDTH-to-1 bit mux: captures a word under valid/ready and
// emits bits in_len+1 times, stepping the mux select up (or down when MSB_FIRST).
module bit_serializer #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned SEL_W     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   len_q, len_d;
  logic [SEL_W-1:0]   last_idx;
  logic               accept;
  logic               beat;

  // Outputs decode registers only, except in_ready which looks through out_ready.
  always_comb begin
    out_valid = (state_q == StShift);
    busy      = out_valid;
    sel       = sel_q;
    out_bit   = out_valid & word_q[sel_q];
    last_idx  = MSB_FIRST ? '0 : len_q;
    out_last  = out_valid && (sel_q == last_idx);
    beat      = out_valid && out_ready;
    in_ready  = !out_valid || (out_last && out_ready);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    len_d   = len_q;
    if (accept) begin
      state_d = StShift;
      word_d  = in_data;
      len_d   = in_len;
      sel_d   = MSB_FIRST ? in_len : '0;
    end else if (beat) begin
      if (out_last) begin
        state_d = StIdle;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - SEL_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      sel_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an ascending and a descending instance share the inputs and
// are checked against directed expectations and a queue-of-beats reference model.
module tb_bit_serializer;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_data;
  logic [7:0]   in_len;
  logic         in_valid;
  logic         out_ready;

  logic       a_in_ready, a_out_bit, a_out_valid, a_out_last, a_busy;
  logic [7:0] a_sel;
  logic       d_in_ready, d_out_bit, d_out_valid, d_out_last, d_busy;
  logic [7:0] d_sel;

  int checks;
  int errors;

  typedef struct packed {
    logic       b;
    logic [7:0] s;
    logic       l;
  } beat_t;

  beat_t qa[$];
  beat_t qd[$];

  bit_serializer #(.WIDTH(256), .SEL_W(8), .MSB_FIRST(1'b0)) dut_asc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .out_bit  (a_out_bit),
    .out_valid(a_out_valid),
    .out_ready(out_ready),
    .out_last (a_out_last),
    .sel      (a_sel),
    .busy     (a_busy)
  );

  bit_serializer #(.WIDTH(256), .SEL_W(8), .MSB_FIRST(1'b1)) dut_desc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_valid (in_valid),
    .in_ready (d_in_ready),
    .out_bit  (d_out_bit),
    .out_valid(d_out_valid),
    .out_ready(out_ready),
    .out_last (d_out_last),
    .sel      (d_sel),
    .busy     (d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each queue holds the beats still owed for the current word.
  task automatic push_word(input bit desc, input logic [255:0] data, input int len);
    beat_t b;
    int    idx;
    for (int k = 0; k <= len; k++) begin
      idx = desc ? (len - k) : k;
      b.b = data[idx];
      b.s = 8'(idx);
      b.l = (k == len);
      if (desc) qd.push_back(b);
      else qa.push_back(b);
    end
  endtask

  function automatic bit exp_ready(input bit desc);
    int n;
    n = desc ? qd.size() : qa.size();
    return (n == 0) || (n == 1 && out_ready);
  endfunction

  function automatic beat_t exp_head(input bit desc);
    if (desc) return (qd.size() != 0) ? qd[0] : '0;
    return (qa.size() != 0) ? qa[0] : '0;
  endfunction

  task automatic model_edge();
    bit ra, rd;
    ra = exp_ready(1'b0);
    rd = exp_ready(1'b1);
    if (qa.size() != 0 && out_ready) void'(qa.pop_front());
    if (qd.size() != 0 && out_ready) void'(qd.pop_front());
    if (in_valid && ra) push_word(1'b0, in_data, int'(in_len));
    if (in_valid && rd) push_word(1'b1, in_data, int'(in_len));
  endtask

  // Advance across one rising edge; returns on the following falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    qa.delete();
    qd.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", a_out_last); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_sel !== 8'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", a_sel); end
    checks++; if (a_out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit: got %b want 0", a_out_bit); end
    checks++; if (d_sel !== 8'd0 || d_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_desc: got sel %0d valid %b want 0 0", d_sel, d_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready %b valid %b want 1 0", a_in_ready, a_out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_ascending();
    logic [255:0] w;
    logic [7:0]   pat;
    pat = 8'hA5;
    do_reset();
    w = rand_word();
    w[7:0] = pat;
    in_data = w; in_len = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL asc_accept_ready: got %b want 1", a_in_ready); end
    tick();
    in_valid = 1'b0;
    in_data  = rand_word();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL asc_valid beat %0d: got %b want 1", k, a_out_valid); end
      checks++; if (a_sel !== 8'(k)) begin errors++; $display("FAIL asc_sel beat %0d: got %0d want %0d", k, a_sel, k); end
      checks++; if (a_out_bit !== pat[k]) begin errors++; $display("FAIL asc_bit beat %0d: got %b want %b", k, a_out_bit, pat[k]); end
      checks++; if (a_out_last !== (k == 7)) begin errors++; $display("FAIL asc_last beat %0d: got %b want %b", k, a_out_last, (k == 7)); end
      tick();
    end
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL asc_idle: got valid %b ready %b busy %b want 0 1 0", a_out_valid, a_in_ready, a_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] w;
    logic [7:0]   got;
    logic [3:0]   rdy_pat;
    logic [7:0]   prev_sel;
    logic         prev_bit, prev_stall;
    int           n, c;
    rdy_pat = 4'b1001;
    do_reset();
    w = rand_word();
    w[7:0] = 8'hA5;
    in_data = w; in_len = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    tick();
    in_valid = 1'b0;
    got = '0; n = 0; c = 0; prev_stall = 1'b0; prev_sel = '0; prev_bit = 1'b0;
    while (n < 8 && c < 40) begin
      out_ready = rdy_pat[c % 4];
      #1;
      if (prev_stall) begin
        checks++; if (a_sel !== prev_sel || a_out_bit !== prev_bit) begin
          errors++; $display("FAIL bp_hold cycle %0d: got sel %0d bit %b want %0d %b", c, a_sel, a_out_bit, prev_sel, prev_bit);
        end
      end
      if (a_out_valid && out_ready) begin
        got[n] = a_out_bit;
        checks++; if (a_sel !== 8'(n)) begin errors++; $display("FAIL bp_sel hs %0d: got %0d want %0d", n, a_sel, n); end
        checks++; if (a_out_last !== (n == 7)) begin errors++; $display("FAIL bp_last hs %0d: got %b want %b", n, a_out_last, (n == 7)); end
        n++;
      end
      prev_stall = a_out_valid && !out_ready;
      prev_sel   = a_sel;
      prev_bit   = a_out_bit;
      c++;
      tick();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_timeout: got %0d handshakes want 8", n); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL bp_stream: got %h want a5", got); end
    out_ready = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wa, wb;
    logic         want_bit;
    do_reset();
    wa = rand_word();
    wb = rand_word();
    in_data = wa; in_len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_data = wb; in_len = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) in_valid = 1'b0;
      #1;
      want_bit = (k <= 4) ? wa[k-1] : wb[0];
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d: got %b want 1", k, a_out_valid); end
      checks++; if (a_in_ready !== (k >= 4)) begin errors++; $display("FAIL b2b_ready beat %0d: got %b want %b", k, a_in_ready, (k >= 4)); end
      checks++; if (a_out_last !== (k >= 4)) begin errors++; $display("FAIL b2b_last beat %0d: got %b want %b", k, a_out_last, (k >= 4)); end
      checks++; if (a_out_bit !== want_bit) begin errors++; $display("FAIL b2b_bit beat %0d: got %b want %b", k, a_out_bit, want_bit); end
      tick();
    end
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", a_out_valid); end
  endtask

  task automatic test_full_desc();
    logic [255:0] w;
    beat_t        h;
    do_reset();
    w = '0;
    w[255] = 1'b1;
    in_data = w; in_len = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 256; k++) begin
      #1;
      h = exp_head(1'b1);
      checks++; if (d_out_valid !== 1'b1 || d_sel !== 8'(255 - k) || d_sel !== h.s) begin
        errors++; $display("FAIL desc_sel beat %0d: got valid %b sel %0d want 1 %0d", k, d_out_valid, d_sel, 255 - k);
      end
      checks++; if (d_out_bit !== (k == 0)) begin errors++; $display("FAIL desc_bit beat %0d: got %b want %b", k, d_out_bit, (k == 0)); end
      checks++; if (d_out_last !== (k == 255)) begin errors++; $display("FAIL desc_last beat %0d: got %b want %b", k, d_out_last, (k == 255)); end
      tick();
    end
    #1;
    checks++; if (d_out_valid !== 1'b0 || d_sel !== 8'd0) begin
      errors++; $display("FAIL desc_nowrap: got valid %b sel %0d want 0 0", d_out_valid, d_sel);
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] w, w2;
    do_reset();
    w = rand_word();
    in_data = w; in_len = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_sel !== 8'd3) begin
      errors++; $display("FAIL arst_pre: got valid %b sel %0d want 1 3", a_out_valid, a_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got valid %b busy %b want 0 0", a_out_valid, a_busy);
    end
    rst_n = 1'b1;
    qa.delete();
    qd.delete();
    #1;
    checks++; if (a_in_ready !== 1'b1 || a_sel !== 8'd0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL arst_release: got ready %b sel %0d busy %b want 1 0 0", a_in_ready, a_sel, a_busy);
    end
    @(negedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_resume: got %b want 0", a_out_valid); end
    w2 = rand_word();
    in_data = w2; in_len = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (a_sel !== 8'(k) || a_out_bit !== w2[k]) begin
        errors++; $display("FAIL arst_next beat %0d: got sel %0d bit %b want %0d %b", k, a_sel, a_out_bit, k, w2[k]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    beat_t ha, hd;
    bit    va, vd;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = rand_word();
      in_len    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      #1;
      va = (qa.size() != 0);
      vd = (qd.size() != 0);
      ha = exp_head(1'b0);
      hd = exp_head(1'b1);
      checks++; if (a_out_valid !== va || a_busy !== va || a_in_ready !== exp_ready(1'b0)) begin
        errors++; $display("FAIL rnd_asc_hs cyc %0d: got valid %b ready %b want %b %b", cyc, a_out_valid, a_in_ready, va, exp_ready(1'b0));
      end
      if (va) begin
        checks++; if (a_sel !== ha.s || a_out_bit !== ha.b || a_out_last !== ha.l) begin
          errors++; $display("FAIL rnd_asc_beat cyc %0d: got sel %0d bit %b last %b want %0d %b %b", cyc, a_sel, a_out_bit, a_out_last, ha.s, ha.b, ha.l);
        end
      end
      checks++; if (d_out_valid !== vd || d_busy !== vd || d_in_ready !== exp_ready(1'b1)) begin
        errors++; $display("FAIL rnd_desc_hs cyc %0d: got valid %b ready %b want %b %b", cyc, d_out_valid, d_in_ready, vd, exp_ready(1'b1));
      end
      if (vd) begin
        checks++; if (d_sel !== hd.s || d_out_bit !== hd.b || d_out_last !== hd.l) begin
          errors++; $display("FAIL rnd_desc_beat cyc %0d: got sel %0d bit %b last %b want %0d %b %b", cyc, d_sel, d_out_bit, d_out_last, hd.s, hd.b, hd.l);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_len    = '0;
    test_reset();
    test_ascending();
    test_backpressure();
    test_back_to_back();
    test_full_desc();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Sequential front end for the 256-to-1 bit multiplexer. The block captures a packed WIDTH-bit word under a valid/ready handshake and streams its bits out one per accepted beat. It does this by stepping an internal index that drives the mux select. Output bit 0 is in[0] when ascending, or in[in_len] when MSB_FIRST=1, and out_last marks the final bit.

## Interface
- WIDTH, 256, number of bits in the packed input word; power of two, at least 2
- SEL_W, 8, select/index width; equals log2(WIDTH)
- MSB_FIRST, 0, 0 = emit indices 0..in_len ascending; 1 = emit in_len..0 descending

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  packed word; bit i is in_data[i]
- in_len  input  SEL_W  last index to emit (bits emitted = in_len+1); sampled with in_data
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- out_bit  output  1  current serial bit = captured_word[sel]
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit this cycle
- out_last  output  1  current bit is the final one of the word
- sel  output  SEL_W  current index into the captured word (the mux select)
- busy  output  1  high while in SHIFT

## Operation
- States: IDLE and SHIFT.
- Storage: WIDTH-bit word register, SEL_W-bit index `sel`, SEL_W-bit `len`.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_data and in_len; sel <= (MSB_FIRST ? in_len : 0); go to SHIFT.
- SHIFT:
  - out_valid=1 and out_bit=word[sel].
  - out_last=1 when sel == (MSB_FIRST ? 0 : len).
  - A beat completes when out_valid&&out_ready. On a non-last beat, sel steps by +1 (descending mode: −1).
  - While out_ready=0, sel, out_bit and out_last hold stable.
- Last beat completes:
  - If in_valid is also high, capture the new word and stay in SHIFT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- in_ready = IDLE || (out_valid && out_last && out_ready). This is a combinational path from out_ready to in_ready and is intended.
- in_len=0 gives a single-beat word, with out_last=1 on its only beat.
- in_len=WIDTH−1 emits all bits; the index never wraps.
- Upstream may drop in_valid or change in_data at will outside an accepting cycle; only the accepting cycle is sampled.
- Reset (asynchronous, any time including mid-word):
  - State goes to IDLE; sel, len and word go to 0.
  - Any partially sent word is discarded and is not resumed after reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, sel=0, out_bit=0.
- Latency:
  - Input accepted at edge T → first bit valid in the cycle after T.
  - With out_ready held at 1, a word of in_len+1 bits occupies exactly in_len+1 cycles.
- Throughput: 1 bit/cycle sustained across words when in_valid is high on each last beat.
- sel, out_bit, out_last and out_valid are registered or decoded from registers only. None depends combinationally on out_ready or in_valid.

## Test plan
- Reset, then ascending stream (MSB_FIRST=0):
  - Stimulus: in_data=256'h…A5 (low byte 8'hA5), in_len=7, out_ready=1.
  - Required: bits 1,0,1,0,0,1,0,1 over 8 cycles; sel 0..7; out_last only on sel=7; then IDLE with in_ready=1.
- Backpressure:
  - Stimulus: same word, out_ready toggling 1,0,0,1,…
  - Required: sel and out_bit hold during the 0 cycles; the same 8-bit sequence appears on handshakes only; no bit is lost or duplicated.
- Back-to-back:
  - Stimulus: word A (in_len=3) followed immediately by word B (in_len=0), in_valid held high.
  - Required: 5 consecutive valid beats with no idle cycle; out_last on beats 4 and 5; in_ready=1 exactly on those two cycles.
- Full width, descending (MSB_FIRST=1):
  - Stimulus: in_data=1<<255, in_len=255.
  - Required: first beat sel=255 with out_bit=1; next 255 beats out_bit=0; last beat sel=0 with out_last=1; no wrap to 255.
- Asynchronous reset mid-word:
  - Stimulus: assert rst_n=0 between clock edges after 3 of 8 bits have been sent.
  - Required: out_valid=0 immediately, without waiting for a clock edge; after release, state is IDLE with in_ready=1 and sel=0; the next word starts at its own index 0.
